ifmap_row_tagger: RTL

IFMAP_ROW_TAGGER -- requirements
Module: ifmap_row_tagger

---
 rtl/ifmap_row_tagger.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ifmap_row_tagger.sv
// rtl/ifmap_row_tagger.sv - tags ifmap pixels with row start/end flags ahead of the circular buffer
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   start                       : frame launch pulse, honoured only when idle
//   row_len, num_rows           : frame geometry, latched on an accepted start
//   pad                         : (ROW_TAGGER_PAD_EN only) per-row zero padding, latched on start
//   in_valid, in_data, in_ready : upstream pixel handshake
//   buf_ready, write_en         : push handshake into the ifmap circular buffer
//   out_data                    : pushed word {start_flag, end_flag, pixel}
//   busy, done                  : frame activity and one-cycle completion pulse
// Build option: define ROW_TAGGER_PAD_EN to add a leading and trailing zero word to every row.
module ifmap_row_tagger #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_ROW    = 32,
  parameter int CNT_W      = $clog2(MAX_ROW + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_W-1:0]      row_len,
  input  logic [CNT_W-1:0]      num_rows,
`ifdef ROW_TAGGER_PAD_EN
  input  logic                  pad,
`endif
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  buf_ready,
  output logic                  write_en,
  output logic [DATA_WIDTH+1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]      row_len_q, num_rows_q;
  logic [CNT_W-1:0]      col_cnt, row_cnt;
  logic                  out_vld;
  logic [DATA_WIDTH+1:0] out_reg;
  logic [DATA_WIDTH+1:0] load_word;
  logic                  slot_free, start_ok, load, row_end, frame_end;
  logic                  last_col, last_row;

`ifdef ROW_TAGGER_PAD_EN
  // Position inside a padded row: leading zero word, pixels, trailing zero word.
  typedef enum logic [1:0] {PH_LEAD, PH_PIX, PH_TRAIL} phase_t;
  phase_t phase;
  logic   pad_q;
`endif

  // The output register can take a new word if empty or being drained this cycle.
  assign slot_free = !out_vld || buf_ready;
  assign start_ok  = start && (state == ST_IDLE);
  assign last_col  = (col_cnt == row_len_q - CNT_W'(1));
  assign last_row  = (row_cnt == num_rows_q - CNT_W'(1));
  assign frame_end = row_end && last_row;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          // A zero-sized frame has nothing to stream and completes immediately.
          if (row_len == '0 || num_rows == '0) state_nxt = ST_DONE;
          else                                 state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: if (frame_end) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (slot_free) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy     = (state == ST_STREAM) || (state == ST_DRAIN);
    done     = (state == ST_DONE);
    write_en = out_vld && buf_ready;
    out_data = out_reg;
  end

  // Word source selection: upstream pixel, or an internally generated pad word.
  always_comb begin
    in_ready  = (state == ST_STREAM) && slot_free;
    load      = in_valid && in_ready;
    load_word = {col_cnt == '0, last_col, in_data};
    row_end   = load && last_col;
`ifdef ROW_TAGGER_PAD_EN
    if (pad_q) begin
      // Pad words need no upstream pixel, so upstream is held off while they load.
      in_ready = (state == ST_STREAM) && slot_free && (phase == PH_PIX);
      load     = (state == ST_STREAM) && slot_free && ((phase != PH_PIX) || in_valid);
      row_end  = load && (phase == PH_TRAIL);
      case (phase)
        PH_LEAD: load_word = {2'b10, {DATA_WIDTH{1'b0}}};
        PH_PIX:  load_word = {2'b00, in_data};
        default: load_word = {2'b01, {DATA_WIDTH{1'b0}}};
      endcase
    end
`endif
  end

  // Frame geometry latches and row/column position
  always_ff @(posedge clk) begin
    if (rst) begin
      row_len_q  <= '0;
      num_rows_q <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
`ifdef ROW_TAGGER_PAD_EN
      pad_q      <= 1'b0;
      phase      <= PH_LEAD;
`endif
    end else if (start_ok) begin
      row_len_q  <= row_len;
      num_rows_q <= num_rows;
      col_cnt    <= '0;
      row_cnt    <= '0;
`ifdef ROW_TAGGER_PAD_EN
      pad_q      <= pad;
      phase      <= PH_LEAD;
`endif
    end else if (load) begin
`ifdef ROW_TAGGER_PAD_EN
      if (pad_q) begin
        case (phase)
          PH_LEAD: phase <= PH_PIX;
          PH_PIX: begin
            if (last_col) begin
              col_cnt <= '0;
              phase   <= PH_TRAIL;
            end else begin
              col_cnt <= col_cnt + CNT_W'(1);
            end
          end
          default: begin
            phase   <= PH_LEAD;
            row_cnt <= row_cnt + CNT_W'(1);
          end
        endcase
      end else
`endif
      if (last_col) begin
        // Next row starts on the very next pixel; no bubble between rows.
        col_cnt <= '0;
        row_cnt <= row_cnt + CNT_W'(1);
      end else begin
        col_cnt <= col_cnt + CNT_W'(1);
      end
    end
  end

  // One-entry output register; a push and a load in the same cycle keep full rate.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_reg <= '0;
    end else if (load) begin
      out_vld <= 1'b1;
      out_reg <= load_word;
    end else if (buf_ready) begin
      out_vld <= 1'b0;
    end
  end

endmodule
